// File: rtl/regbank_access_ctrl.sv
// Register-bank bus master: two operand reads, execute handshake,
// optional result write-back.
module regbank_access_ctrl #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic [ADDR_W-1:0] dst,
   input  logic              wb_en,
   input  logic              abort,
   output logic              busy,
   output logic              ops_valid,
   input  logic              ops_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   input  logic              result_valid,
   input  logic [DATA_W-1:0] result_data,
   output logic              done,
   output logic              readEn,
   output logic              writeEn,
   output logic [ADDR_W-1:0] addressBus,
   output logic [DATA_W-1:0] writeData,
   input  logic [DATA_W-1:0] readData
);

   typedef enum logic [2:0] {
      IDLE, RD_A, RD_B, CAP_B, OPS, EXEC, WB
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] srcb_q;
   logic [ADDR_W-1:0] dst_q;
   logic              wb_q;

   // Bank-side strobes are registered from the next state so they never glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         srcb_q     <= '0;
         dst_q      <= '0;
         wb_q       <= 1'b0;
         busy       <= 1'b0;
         ops_valid  <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         done       <= 1'b0;
         readEn     <= 1'b0;
         writeEn    <= 1'b0;
         addressBus <= '0;
         writeData  <= '0;
      end else begin
         readEn     <= 1'b0;
         writeEn    <= 1'b0;
         addressBus <= '0;
         writeData  <= '0;
         ops_valid  <= 1'b0;
         done       <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     srcb_q     <= src_b;
                     dst_q      <= dst;
                     wb_q       <= wb_en;
                     state      <= RD_A;
                     busy       <= 1'b1;
                     readEn     <= 1'b1;
                     addressBus <= src_a;
                  end
               end
               RD_A: begin
                  state      <= RD_B;
                  readEn     <= 1'b1;
                  addressBus <= srcb_q;
               end
               RD_B: begin
                  op_a  <= readData;
                  state <= CAP_B;
               end
               CAP_B: begin
                  op_b      <= readData;
                  state     <= OPS;
                  ops_valid <= 1'b1;
               end
               OPS: begin
                  if (ops_ready) state <= EXEC;
                  else ops_valid <= 1'b1;
               end
               EXEC: begin
                  if (result_valid) begin
                     if (wb_q) begin
                        state      <= WB;
                        writeEn    <= 1'b1;
                        addressBus <= dst_q;
                        writeData  <= result_data;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
               WB: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_regbank_access_ctrl.sv
// Directed bench for regbank_access_ctrl with a behavioural
// registered-read register bank.
module tb_regbank_access_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] src_a = '0, src_b = '0, dst = '0;
   logic       wb_en = 1'b0, abort = 1'b0;
   logic       busy, ops_valid, done, readEn, writeEn;
   logic       ops_ready = 1'b0, result_valid = 1'b0;
   logic [3:0] op_a, op_b, addressBus, writeData;
   logic [3:0] result_data = '0;
   logic [3:0] readData = '0;

   logic [3:0] mem [16];
   logic       pre_en = 1'b0;
   logic [3:0] pre_a = '0, pre_d = '0;
   int         wr_cnt = 0;
   int         n_run = 0, n_fail = 0;
   int         w0;

   regbank_access_ctrl #(.DATA_W(4), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_a(src_a), .src_b(src_b), .dst(dst),
      .wb_en(wb_en), .abort(abort), .busy(busy),
      .ops_valid(ops_valid), .ops_ready(ops_ready),
      .op_a(op_a), .op_b(op_b),
      .result_valid(result_valid), .result_data(result_data),
      .done(done), .readEn(readEn), .writeEn(writeEn),
      .addressBus(addressBus), .writeData(writeData),
      .readData(readData)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_en) mem[pre_a] <= pre_d;
      if (writeEn) begin
         mem[addressBus] <= writeData;
         wr_cnt <= wr_cnt + 1;
      end
      if (readEn) readData <= mem[addressBus];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [3:0] a, input logic [3:0] d);
      pre_a = a; pre_d = d; pre_en = 1'b1;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic to_ops(input logic [3:0] sa, input logic [3:0] sb,
                         input logic [3:0] d, input logic w,
                         input logic [3:0] ea, input logic [3:0] eb);
      src_a = sa; src_b = sb; dst = d; wb_en = w; start = 1'b1;
      tick();
      start = 1'b0;
      chk("rda_en", readEn, 1);
      chk("rda_addr", addressBus, sa);
      chk("rda_busy", busy, 1);
      tick();
      chk("rdb_en", readEn, 1);
      chk("rdb_addr", addressBus, sb);
      chk("rdb_vld", ops_valid, 0);
      tick();
      chk("capb_en", readEn, 0);
      chk("capb_opa", op_a, ea);
      chk("capb_vld", ops_valid, 0);
      tick();
      chk("ops_vld", ops_valid, 1);
      chk("ops_opa", op_a, ea);
      chk("ops_opb", op_b, eb);
   endtask

   task automatic finish_seq(input logic w, input logic [3:0] res,
                             input logic [3:0] d);
      ops_ready = 1'b1;
      tick();
      ops_ready = 1'b0;
      chk("exec_vld", ops_valid, 0);
      chk("exec_busy", busy, 1);
      result_valid = 1'b1; result_data = res;
      tick();
      result_valid = 1'b0;
      if (w) begin
         chk("wb_en", writeEn, 1);
         chk("wb_addr", addressBus, d);
         chk("wb_data", writeData, res);
         chk("wb_rden", readEn, 0);
         chk("wb_done", done, 0);
         tick();
      end
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 0);
      chk("done_wren", writeEn, 0);
      tick();
      chk("done_clr", done, 0);
   endtask

   initial begin
      #1;
      chk("rst_outs", {busy, ops_valid, done, readEn, writeEn,
                       op_a, op_b, addressBus, writeData}, 0);
      tick();
      rst = 1'b1;
      tick();
      chk("idle_busy", busy, 0);

      // basic read-read-writeback
      preload(4'd3, 4'hA);
      preload(4'd7, 4'h5);
      w0 = wr_cnt;
      to_ops(4'd3, 4'd7, 4'd9, 1'b1, 4'hA, 4'h5);
      finish_seq(1'b1, 4'hF, 4'd9);
      chk("t1_wrcnt", wr_cnt, w0 + 1);
      chk("t1_r9", mem[9], 4'hF);
      chk("t1_hold_opa", op_a, 4'hA);

      // no write-back
      w0 = wr_cnt;
      to_ops(4'd3, 4'd7, 4'd9, 1'b0, 4'hA, 4'h5);
      finish_seq(1'b0, 4'h6, 4'd9);
      chk("t2_wrcnt", wr_cnt, w0);
      chk("t2_r9", mem[9], 4'hF);

      // execute-stage backpressure
      to_ops(4'd7, 4'd3, 4'd9, 1'b0, 4'h5, 4'hA);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_vld", ops_valid, 1);
         chk("bp_ops", {op_a, op_b}, 8'h5A);
         chk("bp_bus", {readEn, writeEn}, 0);
      end
      finish_seq(1'b0, 4'h0, 4'd9);

      // dst aliases src_a
      preload(4'd2, 4'h3);
      to_ops(4'd2, 4'd7, 4'd2, 1'b1, 4'h3, 4'h5);
      finish_seq(1'b1, 4'hC, 4'd2);
      chk("t4_r2", mem[2], 4'hC);
      to_ops(4'd2, 4'd2, 4'd0, 1'b0, 4'hC, 4'hC);
      finish_seq(1'b0, 4'h0, 4'd0);

      // abort in OPS
      w0 = wr_cnt;
      to_ops(4'd3, 4'd7, 4'd9, 1'b1, 4'hA, 4'h5);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abo_busy", busy, 0);
      chk("abo_vld", ops_valid, 0);
      chk("abo_done", done, 0);
      tick();
      chk("abo_done2", done, 0);
      chk("abo_wrcnt", wr_cnt, w0);
      chk("abo_r9", mem[9], 4'hF);

      // abort in WB: write still lands
      to_ops(4'd3, 4'd7, 4'd9, 1'b1, 4'hA, 4'h5);
      ops_ready = 1'b1;
      tick();
      ops_ready = 1'b0;
      result_valid = 1'b1; result_data = 4'h1;
      tick();
      result_valid = 1'b0;
      chk("abw_wren", writeEn, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abw_done", done, 0);
      chk("abw_busy", busy, 0);
      chk("abw_wrcnt", wr_cnt, w0 + 1);
      chk("abw_r9", mem[9], 4'h1);
      tick();
      chk("abw_done2", done, 0);

      // async reset during RD_B
      w0 = wr_cnt;
      src_a = 4'd3; src_b = 4'd7; dst = 4'd9; wb_en = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("rstm_rdb", readEn, 1);
      #2 rst = 1'b0;
      #1;
      chk("rstm_outs", {busy, ops_valid, done, readEn, writeEn,
                        op_a, op_b, addressBus, writeData}, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("rstm_wrcnt", wr_cnt, w0);
      chk("rstm_idle", busy, 0);

      // back-to-back start in the done cycle
      to_ops(4'd3, 4'd7, 4'd9, 1'b0, 4'hA, 4'h5);
      ops_ready = 1'b1;
      tick();
      ops_ready = 1'b0;
      result_valid = 1'b1; result_data = 4'h0;
      tick();
      result_valid = 1'b0;
      chk("b2b_done", done, 1);
      src_a = 4'd7; src_b = 4'd3; dst = 4'd0; wb_en = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_done_clr", done, 0);
      chk("b2b_busy", busy, 1);
      chk("b2b_rd", {readEn, addressBus}, 5'h17);
      tick();
      chk("b2b_rdb", addressBus, 4'd3);
      tick();
      chk("b2b_opa", op_a, 4'h5);
      tick();
      chk("b2b_ops", {ops_valid, op_b}, 5'h1A);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("b2b_abort", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
